// File: rtl/hbmc_rst_pkg.sv
// Shared encodings and constants for the HyperRAM/SoC reset sequencer.
// Used by hbmc_reset_seq (optional watchdog build: RST_SEQ_WDT_EN).
package hbmc_rst_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_POR       = 3'd1,
    ST_HRAM_RST  = 3'd2,
    ST_HRAM_REC  = 3'd3,
    ST_SOC_DLY   = 3'd4,
    ST_RUN       = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_LOCK = 2'd2,
    CAUSE_SW   = 2'd3
  } rst_cause_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hbmc_sync_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
// The level output follows the synchronized input only after it has differed for DEBOUNCE_CYCLES cycles.
module hbmc_sync_debounce
  import hbmc_rst_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 65536,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [DB_W-1:0]        cnt_q;
  logic                   level_q;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      level_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      if (synced == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        level_q <= synced;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + DB_ONE;
      end
    end
  end

endmodule

// File: rtl/hbmc_reset_seq.sv
// Power-up / reset sequencer: pulses HyperRAM RESET#, waits out recovery, then releases SoC reset.
// Optional watchdog restart is built when RST_SEQ_WDT_EN is defined.
module hbmc_reset_seq
  import hbmc_rst_pkg::*;
#(
  parameter int POR_HOLD_CYCLES       = 15000,
  parameter int HRAM_RST_PULSE_CYCLES = 20,
  parameter int HRAM_RST_REC_CYCLES   = 40,
  parameter int SOC_DLY_CYCLES        = 16,
  parameter int DEBOUNCE_CYCLES       = 65536
`ifdef RST_SEQ_WDT_EN
  ,
  parameter int WDT_TIMEOUT_CYCLES    = 100000000
`endif
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       btn_n,
  input  logic       clk_locked,
  input  logic       sw_rst_req,
`ifdef RST_SEQ_WDT_EN
  input  logic       wdt_kick,
`endif
  output logic       soc_resetn,
  output logic       hram_reset_n,
  output logic [2:0] seq_state,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int MAX_CYC = max2(max2(POR_HOLD_CYCLES, HRAM_RST_PULSE_CYCLES),
                                max2(HRAM_RST_REC_CYCLES, SOC_DLY_CYCLES));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] POR_LOAD   = CNT_W'(POR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(HRAM_RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'(HRAM_RST_REC_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD   = CNT_W'(SOC_DLY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_sync;
  logic                   btn_level;
  logic                   btn_level_q;
  logic                   sw_q;
  logic                   sw_prev_q;
  logic                   btn_evt;
  logic                   sw_evt;
  logic                   wdt_evt;

  seq_state_e       state_q, state_d;
  rst_cause_e       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             por_done_q, por_done_d;
  logic             soc_q;
  logic             hram_q;
  logic [7:0]       count_q;

  hbmc_sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_btn_db (
    .clk     (clkin),
    .rst_n   (resetn),
    .din_i   (btn_n),
    .level_o (btn_level)
  );

  assign locked_sync = lock_sync_q[SYNC_STAGES-1];

  // sw_rst_req is registered before edge detection, giving one extra cycle of latency.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_sync_q <= '0;
      btn_level_q <= 1'b1;
      sw_q        <= 1'b0;
      sw_prev_q   <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked};
      btn_level_q <= btn_level;
      sw_q        <= sw_rst_req;
      sw_prev_q   <= sw_q;
    end
  end

  assign btn_evt = btn_level_q & ~btn_level;
  assign sw_evt  = sw_q & ~sw_prev_q;

`ifdef RST_SEQ_WDT_EN
  localparam int               WDT_W    = $clog2(WDT_TIMEOUT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT_CYCLES - 1);
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

  logic [WDT_W-1:0] wdt_q;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      wdt_q <= '0;
    end else if (state_q != ST_RUN || wdt_kick) begin
      wdt_q <= '0;
    end else if (wdt_q != WDT_LAST) begin
      wdt_q <= wdt_q + WDT_ONE;
    end
  end

  assign wdt_evt = (state_q == ST_RUN) && !wdt_kick && (wdt_q == WDT_LAST);
`else
  assign wdt_evt = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d signal gets a default first; a path that skips one would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    por_done_d = por_done_q;

    // Losing clock lock overrides everything else.
    if (state_q != ST_WAIT_LOCK && !locked_sync) begin
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      cause_d = CAUSE_LOCK;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_sync) begin
            if (por_done_q) begin
              state_d = ST_HRAM_RST;
              cnt_d   = PULSE_LOAD;
            end else begin
              state_d = ST_POR;
              cnt_d   = POR_LOAD;
            end
          end
        end
        ST_POR: begin
          if (cnt_q == '0) begin
            state_d    = ST_HRAM_RST;
            cnt_d      = PULSE_LOAD;
            por_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HRAM_RST: begin
          if (cnt_q == '0) begin
            state_d = ST_HRAM_REC;
            cnt_d   = REC_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_HRAM_REC: begin
          if (cnt_q == '0) begin
            state_d = ST_SOC_DLY;
            cnt_d   = DLY_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SOC_DLY: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_RUN: begin
          // Restart requests are single-cycle pulses, so anything arriving outside RUN is lost.
          if (btn_evt) begin
            state_d = ST_HRAM_RST;
            cnt_d   = PULSE_LOAD;
            cause_d = CAUSE_BTN;
          end else if (wdt_evt || sw_evt) begin
            state_d = ST_HRAM_RST;
            cnt_d   = PULSE_LOAD;
            cause_d = CAUSE_SW;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge that enters the state.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_WAIT_LOCK;
      cnt_q      <= '0;
      cause_q    <= CAUSE_POR;
      por_done_q <= 1'b0;
      soc_q      <= 1'b0;
      hram_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      por_done_q <= por_done_d;
      hram_q     <= !(state_d inside {ST_WAIT_LOCK, ST_POR, ST_HRAM_RST});
      soc_q      <= (state_d == ST_RUN);
      if (state_d == ST_HRAM_RST && state_q != ST_HRAM_RST && count_q != 8'hFF) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign soc_resetn   = soc_q;
  assign hram_reset_n = hram_q;
  assign seq_state    = state_q;
  assign rst_cause    = cause_q;
  assign rst_count    = count_q;

endmodule

// File: tb/tb_hbmc_reset_seq.sv
// Self-checking bench for hbmc_reset_seq: directed sequences, a stimulus table and a
// randomized phase compared against a timeline model of the sequencer.
module tb_hbmc_reset_seq;
  import hbmc_rst_pkg::*;

  localparam int P_POR   = 10;
  localparam int P_PULSE = 4;
  localparam int P_REC   = 6;
  localparam int P_DLY   = 3;
  localparam int P_DB    = 8;
  localparam int SEQ_LEN = P_PULSE + P_REC + P_DLY;
  // Two synchronizer edges plus one decision edge before POR is entered.
  localparam int PWR_HRAM_EDGES = SYNC_STAGES + 1 + P_POR + P_PULSE;
  localparam int NR  = 500;
  localparam int OFF = 16;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       btn_n;
  logic       clk_locked;
  logic       sw_rst_req;
  logic       soc_resetn;
  logic       hram_reset_n;
  logic [2:0] seq_state;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;
`ifdef RST_SEQ_WDT_EN
  logic       wdt_kick = 1'b0;
`endif

  hbmc_reset_seq #(
    .POR_HOLD_CYCLES       (P_POR),
    .HRAM_RST_PULSE_CYCLES (P_PULSE),
    .HRAM_RST_REC_CYCLES   (P_REC),
    .SOC_DLY_CYCLES        (P_DLY),
    .DEBOUNCE_CYCLES       (P_DB)
  ) dut (
    .clkin        (clkin),
    .resetn       (resetn),
    .btn_n        (btn_n),
    .clk_locked   (clk_locked),
    .sw_rst_req   (sw_rst_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick     (wdt_kick),
`endif
    .soc_resetn   (soc_resetn),
    .hram_reset_n (hram_reset_n),
    .seq_state    (seq_state),
    .rst_cause    (rst_cause),
    .rst_count    (rst_count)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int         btn_low;
    int         sw_high;
    int         exp_seqs;
    logic [1:0] cause;
    string      name;
  } vec_t;

  vec_t       vecs[6];
  int         errors = 0;
  int         checks = 0;
  int         exp_count;
  logic [1:0] exp_cause;
  int         n, nseq, len, t, s;
  bit         prev_soc, all_diff, bev, sev, cur_sw, cur_btn;
  logic [2:0] exp_state;
  bit         sw_h  [NR+OFF];
  bit         btn_h [NR+OFF];
  bit         lvl_h [NR+OFF];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  function automatic int sat_inc(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int k;
    k = 0;
    while (seq_state !== target && k < budget) begin
      step();
      k++;
    end
    check(name, seq_state, target);
  endtask

  task automatic edges_until_high(input bit use_soc, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (((use_soc ? soc_resetn : hram_reset_n) !== 1'b1) && cnt < 200);
  endtask

  task automatic sw_pulse();
    @(negedge clkin);
    sw_rst_req = 1'b1;
    step();
    @(negedge clkin);
    sw_rst_req = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{5,   0,   0, CAUSE_POR, "btn_glitch5"};
    vecs[1] = '{7,   0,   0, CAUSE_POR, "btn_short7"};
    vecs[2] = '{8,   0,   1, CAUSE_BTN, "btn_exact8"};
    vecs[3] = '{20,  0,   1, CAUSE_BTN, "btn_press20"};
    vecs[4] = '{0,   1,   1, CAUSE_SW,  "sw_pulse1"};
    vecs[5] = '{0,   100, 1, CAUSE_SW,  "sw_hold100"};

    resetn = 1'b0; clk_locked = 1'b1; btn_n = 1'b1; sw_rst_req = 1'b0;
    repeat (3) step();
    check("rst_soc",   soc_resetn,   1'b0);
    check("rst_hram",  hram_reset_n, 1'b0);
    check("rst_state", seq_state,    ST_WAIT_LOCK);
    check("rst_cause", rst_cause,    CAUSE_POR);
    check("rst_count", rst_count,    8'd0);

    // Power-up
    @(negedge clkin);
    resetn = 1'b1;
    edges_until_high(1'b0, n);
    check("pwr_hram_low_edges", n, PWR_HRAM_EDGES);
    edges_until_high(1'b1, n);
    check("pwr_soc_after_hram", n, P_REC + P_DLY);
    exp_count = 1; exp_cause = CAUSE_POR;
    check("pwr_state", seq_state, ST_RUN);
    check("pwr_count", rst_count, exp_count);
    check("pwr_cause", rst_cause, exp_cause);

    // Software request latency: sampled at edge k, resets drop after edge k+1
    repeat (5) step();
    @(negedge clkin);
    sw_rst_req = 1'b1;
    step();
    check("sw_lat_edge_k", soc_resetn, 1'b1);
    @(negedge clkin);
    sw_rst_req = 1'b0;
    step();
    check("sw_lat_soc",   soc_resetn,   1'b0);
    check("sw_lat_hram",  hram_reset_n, 1'b0);
    check("sw_lat_state", seq_state,    ST_HRAM_RST);
    edges_until_high(1'b0, n);
    check("sw_hram_pulse", n, P_PULSE);
    exp_count = sat_inc(exp_count); exp_cause = CAUSE_SW;
    check("sw_count", rst_count, exp_count);
    check("sw_cause", rst_cause, exp_cause);
    wait_state(ST_RUN, 50, "sw_back_to_run");

    // Stimulus table: button and software request patterns applied from RUN
    for (int v = 0; v < 6; v++) begin
      nseq = 0;
      len  = (vecs[v].btn_low > vecs[v].sw_high) ? vecs[v].btn_low : vecs[v].sw_high;
      for (int c = 0; c < len + 40; c++) begin
        @(negedge clkin);
        btn_n      = !(c < vecs[v].btn_low);
        sw_rst_req = (c < vecs[v].sw_high);
        prev_soc   = soc_resetn;
        step();
        if (prev_soc && !soc_resetn) nseq++;
      end
      for (int k = 0; k < vecs[v].exp_seqs; k++) exp_count = sat_inc(exp_count);
      if (vecs[v].exp_seqs > 0) exp_cause = vecs[v].cause;
      check({vecs[v].name, "_seqs"},  nseq,      vecs[v].exp_seqs);
      check({vecs[v].name, "_count"}, rst_count, exp_count);
      check({vecs[v].name, "_cause"}, rst_cause, exp_cause);
      check({vecs[v].name, "_state"}, seq_state, ST_RUN);
    end

    // Lock loss during HRAM_REC, then relock without POR
    sw_pulse();
    exp_count = sat_inc(exp_count);
    wait_state(ST_HRAM_REC, 20, "lock_reach_rec");
    @(negedge clkin);
    clk_locked = 1'b0;
    step();
    step();
    check("lock_sync_delay_state", seq_state, ST_HRAM_REC);
    step();
    check("lock_loss_state", seq_state,    ST_WAIT_LOCK);
    check("lock_loss_hram",  hram_reset_n, 1'b0);
    check("lock_loss_soc",   soc_resetn,   1'b0);
    exp_cause = CAUSE_LOCK;
    check("lock_loss_cause", rst_cause, exp_cause);
    repeat (4) step();
    check("lock_hold_state", seq_state, ST_WAIT_LOCK);
    @(negedge clkin);
    clk_locked = 1'b1;
    step();
    step();
    check("relock_sync_state", seq_state, ST_WAIT_LOCK);
    step();
    check("relock_state", seq_state, ST_HRAM_RST);
    exp_count = sat_inc(exp_count);
    check("relock_count", rst_count, exp_count);
    check("relock_cause", rst_cause, exp_cause);
    wait_state(ST_RUN, 50, "relock_run");
    repeat (20) step();

    // Randomized phase against a timeline model
    for (int k = 0; k < OFF; k++) begin
      sw_h[k] = 1'b0; btn_h[k] = 1'b1; lvl_h[k] = 1'b1;
    end
    s = -1000; cur_sw = 1'b0; cur_btn = 1'b1;
    for (int i = 0; i < NR; i++) begin
      t = OFF + i;
      if (i < NR - 40) begin
        if ($urandom_range(11) == 0) cur_btn = ~cur_btn;
        if ($urandom_range(14) == 0) cur_sw  = ~cur_sw;
      end else begin
        cur_btn = 1'b1; cur_sw = 1'b0;
      end
      @(negedge clkin);
      btn_n = cur_btn; sw_rst_req = cur_sw;
      btn_h[t] = cur_btn; sw_h[t] = cur_sw;
      step();
      // Debounced level flips once the last P_DB synchronized samples all disagree with it.
      all_diff = 1'b1;
      for (int k = t - P_DB - 1; k <= t - 2; k++) if (btn_h[k] == lvl_h[t-1]) all_diff = 1'b0;
      lvl_h[t] = all_diff ? !lvl_h[t-1] : lvl_h[t-1];
      bev = lvl_h[t-2] && !lvl_h[t-1];
      sev = sw_h[t-1] && !sw_h[t-2];
      if ((t - 1) >= s + SEQ_LEN && (bev || sev)) begin
        s = t;
        exp_count = sat_inc(exp_count);
        exp_cause = bev ? CAUSE_BTN : CAUSE_SW;
      end
      exp_state = (t < s + P_PULSE)         ? ST_HRAM_RST :
                  (t < s + P_PULSE + P_REC) ? ST_HRAM_REC :
                  (t < s + SEQ_LEN)         ? ST_SOC_DLY  : ST_RUN;
      check("rand_cycle", {seq_state, hram_reset_n, soc_resetn, rst_cause, rst_count},
            {exp_state, 1'(t >= s + P_PULSE), 1'(t >= s + SEQ_LEN), exp_cause, 8'(exp_count)});
    end

    // resetn asserted mid-SOC_DLY
    sw_pulse();
    wait_state(ST_SOC_DLY, 20, "abort_reach_dly");
    #2;
    resetn = 1'b0;
    #1;
    check("abort_soc",   soc_resetn,   1'b0);
    check("abort_hram",  hram_reset_n, 1'b0);
    check("abort_state", seq_state,    ST_WAIT_LOCK);
    check("abort_count", rst_count,    8'd0);
    check("abort_cause", rst_cause,    CAUSE_POR);
    repeat (3) step();
    @(negedge clkin);
    resetn = 1'b1;
    edges_until_high(1'b0, n);
    check("abort_por_repeat", n, PWR_HRAM_EDGES);
    exp_count = 1; exp_cause = CAUSE_POR;
    check("abort_count_restart", rst_count, exp_count);
    wait_state(ST_RUN, 50, "abort_run");

    // Saturation of rst_count
    for (int i = 0; i < 300; i++) begin
      sw_pulse();
      exp_count = sat_inc(exp_count);
      wait_state(ST_RUN, 50, "sat_run");
    end
    check("sat_count", rst_count, exp_count);
    check("sat_cause", rst_cause, CAUSE_SW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
